// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-requester memory arbiter: FSM state encoding,
// requester ids and the ReadWrite sense used by the memory.
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// and on a tie the requester that was not granted last time wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  always_comb begin
    grant = REQ_A;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = REQ_B;
    end
  end

  assign any = |req;

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between fetch (A) and load/store (B), one access
// at a time in a fixed IDLE/ACCESS/RESP sequence. Define MEM_ARB_STATS_EN for grant counters.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqA,
  input  logic              ReqB,
  input  logic              RwA,
  input  logic              RwB,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] WDataA,
  input  logic [DATA_W-1:0] WDataB,
  output logic              ReadyA,
  output logic              ReadyB,
  output logic [DATA_W-1:0] RDataA,
  output logic [DATA_W-1:0] RDataB,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIn,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0]       GrantCntA,
  output logic [15:0]       GrantCntB,
`endif
  input  logic [DATA_W-1:0] MemDataOut
);

  logic [1:0]        r_state;
  logic              r_lastGrant;
  logic              r_winner;
  logic              r_readyA;
  logic              r_readyB;
  logic [DATA_W-1:0] r_rDataA;
  logic [DATA_W-1:0] r_rDataB;
  logic              r_memEnable;
  logic              r_memReadWrite;
  logic [ADDR_W-1:0] r_memAddress;
  logic [DATA_W-1:0] r_memDataIn;

  logic              w_grant;
  logic              w_any;
  logic              w_selRw;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selWData;

  rr_arbiter2 u_rr (
    .req   ({ReqB, ReqA}),
    .last  (r_lastGrant),
    .grant (w_grant),
    .any   (w_any)
  );

  assign w_selRw    = (w_grant == REQ_B) ? RwB    : RwA;
  assign w_selAddr  = (w_grant == REQ_B) ? AddrB  : AddrA;
  assign w_selWData = (w_grant == REQ_B) ? WDataB : WDataA;

  // The memory-side registers double as the latched request fields, so they
  // are loaded at grant time and hold steady through ACCESS.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state        <= IDLE;
      r_lastGrant    <= REQ_B;
      r_winner       <= REQ_A;
      r_readyA       <= 1'b0;
      r_readyB       <= 1'b0;
      r_rDataA       <= '0;
      r_rDataB       <= '0;
      r_memEnable    <= 1'b0;
      r_memReadWrite <= RW_READ;
      r_memAddress   <= '0;
      r_memDataIn    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_winner       <= w_grant;
            r_memEnable    <= 1'b1;
            r_memReadWrite <= w_selRw;
            r_memAddress   <= w_selAddr;
            r_memDataIn    <= w_selWData;
            r_state        <= ACCESS;
          end
        end
        ACCESS: begin
          r_memEnable <= 1'b0;
          if (r_memReadWrite == RW_READ) begin
            if (r_winner == REQ_A) r_rDataA <= MemDataOut;
            else                   r_rDataB <= MemDataOut;
          end
          if (r_winner == REQ_A) r_readyA <= 1'b1;
          else                   r_readyB <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          r_readyA    <= 1'b0;
          r_readyB    <= 1'b0;
          r_lastGrant <= r_winner;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ReadyA       = r_readyA;
  assign ReadyB       = r_readyB;
  assign RDataA       = r_rDataA;
  assign RDataB       = r_rDataB;
  assign MemEnable    = r_memEnable;
  assign MemReadWrite = r_memReadWrite;
  assign MemAddress   = r_memAddress;
  assign MemDataIn    = r_memDataIn;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_grantCntA;
  logic [15:0] r_grantCntB;

  // Saturating per-requester grant counters, bumped once per completed transaction.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_grantCntA <= '0;
      r_grantCntB <= '0;
    end else if (r_state == RESP) begin
      if (r_winner == REQ_A && r_grantCntA != 16'hFFFF) r_grantCntA <= r_grantCntA + 16'd1;
      if (r_winner == REQ_B && r_grantCntB != 16'hFFFF) r_grantCntB <= r_grantCntB + 16'd1;
    end
  end

  assign GrantCntA = r_grantCntA;
  assign GrantCntB = r_grantCntB;
`endif

endmodule
